// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a DEPTH x BUS_WDT register array, with optional
// fixed wait states and a two-cycle ERROR response for bad transfers.

module ahb_slave_mem_lane #(
    parameter int LB   = 2,
    parameter int LANE = 0
) (
    input  logic [LB-1:0] off,
    input  logic [1:0]    size,
    input  logic          wr_hit,
    input  logic [7:0]    wbyte,
    input  logic [7:0]    rbyte,
    output logic          sel,
    output logic [7:0]    mbyte
);
    localparam logic [LB-1:0] LANE_ID = LB'(LANE);

    // Lane belongs to the naturally aligned 2^size block that holds the offset.
    assign sel   = ((LANE_ID ^ off) >> size) == '0;
    assign mbyte = (wr_hit && sel) ? wbyte : rbyte;
endmodule

module ahb_slave_mem #(
    parameter int BUS_WDT     = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic               i_hclk,
    input  logic               i_hreset_n,
    input  logic               i_hsel,
    input  logic [31:0]        i_haddr,
    input  logic [1:0]         i_htrans,
    input  logic [1:0]         i_hsize,
    input  logic               i_hwrite,
    input  logic [BUS_WDT-1:0] i_hwdata,
    input  logic               i_hready,
    output logic               o_hready,
    output logic [1:0]         o_hresp,
    output logic [BUS_WDT-1:0] o_hrdata
);
    localparam int NB = BUS_WDT / 8;
    localparam int LB = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    localparam logic [32:0] MEM_BYTES = 33'(DEPTH * NB);
    localparam logic [3:0]  WS_INIT   = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    localparam logic [1:0] ST_READY = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_ERR1  = 2'd2;
    localparam logic [1:0] ST_ERR2  = 2'd3;

    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;
    localparam logic [1:0] RESP_OKAY     = 2'd0;
    localparam logic [1:0] RESP_ERROR    = 2'd1;

    logic [1:0]    state;
    logic [3:0]    wait_cnt;
    logic          dp_valid;
    logic          dp_write;
    logic [AW-1:0] dp_idx;
    logic [LB-1:0] dp_off;
    logic [1:0]    dp_size;

    logic [BUS_WDT-1:0] mem [DEPTH];

    logic          trans_act;
    logic          misalign;
    logic          size_err;
    logic          range_err;
    logic          xfer_err;
    logic          accept;
    logic          dp_done;
    logic          wr_en;
    logic          wr_hit;
    logic          rd_load;
    logic [AW-1:0] acc_idx;
    logic [LB-1:0] acc_off;
    logic [AW-1:0] rd_idx;
    logic [BUS_WDT-1:0] mem_rd;
    logic [BUS_WDT-1:0] rd_word;
    logic [NB-1:0]      lane_sel;

    assign acc_idx   = i_haddr[LB +: AW];
    assign acc_off   = i_haddr[LB-1:0];
    assign trans_act = (i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ);

    always_comb begin
        misalign = 1'b0;
        case (i_hsize)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = i_haddr[0];
            2'd2:    misalign = |i_haddr[1:0];
            default: misalign = |i_haddr[2:0];
        endcase
    end

    assign size_err  = (i_hsize == 2'd3) && (BUS_WDT == 32);
    assign range_err = {1'b0, i_haddr} >= MEM_BYTES;
    assign xfer_err  = misalign || size_err || range_err;

    // New address phases are only taken while READY; ERR2 deliberately ignores them.
    assign accept  = i_hsel && i_hready && trans_act && (state == ST_READY);
    assign dp_done = dp_valid && (state == ST_READY);
    assign wr_en   = dp_done && dp_write;

    // Read data is registered one edge ahead of the cycle that shows o_hready=1.
    assign rd_idx  = (state == ST_WAIT) ? dp_idx : acc_idx;
    assign rd_load = (accept && !xfer_err && !i_hwrite && (WAIT_STATES == 0)) ||
                     ((state == ST_WAIT) && (wait_cnt == 4'd0) && !dp_write);
    assign wr_hit  = wr_en && (dp_idx == rd_idx);
    assign mem_rd  = mem[rd_idx];

    for (genvar g = 0; g < NB; g++) begin : g_lane
        ahb_slave_mem_lane #(
            .LB   (LB),
            .LANE (g)
        ) u_lane (
            .off    (dp_off),
            .size   (dp_size),
            .wr_hit (wr_hit),
            .wbyte  (i_hwdata[g*8 +: 8]),
            .rbyte  (mem_rd[g*8 +: 8]),
            .sel    (lane_sel[g]),
            .mbyte  (rd_word[g*8 +: 8])
        );
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state    <= ST_READY;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                ST_READY: begin
                    if (accept) begin
                        if (xfer_err) begin
                            state <= ST_ERR1;
                        end else if (WAIT_STATES != 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WS_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) state <= ST_READY;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                ST_ERR1: state <= ST_ERR2;
                default: state <= ST_READY;
            endcase
        end
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_off   <= '0;
            dp_size  <= 2'd0;
        end else if (accept) begin
            dp_valid <= !xfer_err;
            dp_write <= i_hwrite;
            dp_idx   <= acc_idx;
            dp_off   <= acc_off;
            dp_size  <= i_hsize;
        end else if (dp_done) begin
            dp_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n)  o_hrdata <= '0;
        else if (rd_load) o_hrdata <= rd_word;
    end

    // Storage is intentionally not reset.
    always_ff @(posedge i_hclk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (lane_sel[b]) mem[dp_idx][b*8 +: 8] <= i_hwdata[b*8 +: 8];
            end
        end
    end

    assign o_hready = (state == ST_READY) || (state == ST_ERR2);
    assign o_hresp  = ((state == ST_ERR1) || (state == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 SHALL have parameter BUS_WDT, default 32, data bus width (32 or 64 only).
REQ-002 SHALL have parameter DEPTH, default 256, memory depth in BUS_WDT-wide words (power of 2, >= 2).
REQ-003 SHALL have parameter WAIT_STATES, default 0, wait cycles per OKAY data phase (0..15).
REQ-004 SHALL have port i_hclk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_hreset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port i_hsel  input  1  slave select from the decoder.
REQ-007 SHALL have port i_haddr  input  32  address-phase byte address.
REQ-008 SHALL have port i_htrans  input  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-009 SHALL have port i_hsize  input  2  transfer size: 0=byte, 1=half, 2=word, 3=dword.
REQ-010 SHALL have port i_hwrite  input  1  1=write, 0=read.
REQ-011 SHALL have port i_hwdata  input  BUS_WDT  write data, valid in the data phase.
REQ-012 SHALL have port i_hready  input  1  bus-wide HREADY; high means the previous data phase completes this cycle.
REQ-013 SHALL have port o_hready  output  1  slave ready for the current data phase.
REQ-014 SHALL have port o_hresp  output  2  response: OKAY=0, ERROR=1 (RETRY=2 and SPLIT=3 are never driven).
REQ-015 SHALL have port o_hrdata  output  BUS_WDT  read data.

Function
REQ-016 SHALL accept an address phase only when i_hsel && i_hready && i_htrans is NONSEQ or SEQ, and SHALL latch addr, size and write for the data phase at that edge.
REQ-017 SHALL respond to an accepted IDLE/BUSY, or to an unselected cycle, with a zero-wait OKAY (o_hready=1, o_hresp=OKAY) and no memory access.
REQ-018 SHALL implement FSM states READY, WAIT, ERR1 and ERR2; reset state is READY.
REQ-019 SHALL classify an accepted transfer as an error when any of these hold: byte address >= DEPTH*BUS_WDT/8; the address is misaligned to i_hsize; i_hsize=3 while BUS_WDT=32.
REQ-020 SHALL respond to an error transfer with ERR1 (o_hready=0, o_hresp=ERROR), then ERR2 (o_hready=1, o_hresp=ERROR), then READY; memory SHALL NOT be modified.
REQ-021 SHALL, for a valid transfer with WAIT_STATES=N>0, enter WAIT and drive o_hready=0 with OKAY for exactly N cycles, then drive o_hready=1 with OKAY for one cycle.
REQ-022 SHALL, for a valid transfer with WAIT_STATES=0, complete the data phase in the first cycle (o_hready=1, OKAY).
REQ-023 SHALL, on a write, sample i_hwdata on the completing edge of the data phase (o_hready=1) and update only the byte lanes selected by the latched size and the address low bits, little-endian.
REQ-024 SHALL, on a read, drive the full addressed word on o_hrdata whenever o_hready=1 in that data phase; o_hrdata SHALL hold its previous value at all other times.
REQ-025 SHALL, when a write completes on the same edge that a read to the same word is accepted, return the read data with the newly written bytes merged in.
REQ-026 SHALL, while in WAIT, ERR1 or ERR2, ignore any new address-phase inputs; the next accept SHALL occur only when o_hready=1.
REQ-027 SHALL support back-to-back pipelined transfers at zero wait with no dead cycle between them.
REQ-028 SHALL use internal state of the wait counter (4-bit), the FSM state and the latched data-phase controls, plus a DEPTH x BUS_WDT register array.

Reset
REQ-029 SHALL, on i_hreset_n low at any time, go to READY asynchronously with o_hready=1, o_hresp=OKAY, o_hrdata=0, the wait counter at 0 and the latched data phase cleared; memory contents SHALL be left undefined and not reset.
REQ-030 SHALL, if reset occurs during WAIT or ERR1, abandon the pending transfer with no memory write.

Verification
REQ-031 SHALL pass this test: WAIT_STATES=0, write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> OKAY with no stall, and o_hrdata=0xDEADBEEF in the read data phase.
REQ-032 SHALL pass this test: a byte write of 0xAA to 0x13 over word 0x11223344 -> a later read of 0x10 returns 0xAA223344.
REQ-033 SHALL pass this test: WAIT_STATES=3, read -> o_hready low for exactly 3 cycles, then high with OKAY.
REQ-034 SHALL pass this test: a halfword access to 0x01, or any access at DEPTH*4 -> ERROR for 2 cycles (o_hready 0 then 1), with memory unchanged.
REQ-035 SHALL pass this test: a BUSY or IDLE transfer, or i_hsel=0 -> o_hready=1, OKAY, no access.
REQ-036 SHALL pass this test: reset asserted mid-WAIT of a write -> o_hready=1 immediately and the target word unchanged.
